axis_pkt_arbiter: RTL
=====================

# axis_pkt_arbiter

Packet-level round-robin arbiter that merges `NUM_PORTS` 8-bit AXI-Stream packet sources into one stream. Each source holds the output for a whole packet, from its first beat through its `tlast` beat. A registered output stage tags each beat with its source port. The block sits upstream of the packet FIFO on the Ethernet receive path, so several MAC/parser channels can share one store-and-forward buffer, and it provides per-port packet counters for status registers.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of source ports; legal range 2..8.
- `CNT_W`, 16: width of each per-port packet counter.
- `ID_W` (localparam): `$clog2(NUM_PORTS)`.

Ports:
- `axis_aclk` in 1: single clock for all logic.
- `axis_aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in `NUM_PORTS*8`: port *i* occupies bits `[8i+7:8i]`.
- `s_axis_tvalid` in `NUM_PORTS`: per-port valid.
- `s_axis_tlast` in `NUM_PORTS`: per-port end of packet.
- `s_axis_tready` out `NUM_PORTS`: per-port ready; asserted only for the granted port.
- `m_axis_tdata` out 8: registered output data.
- `m_axis_tvalid` out 1: registered output valid.
- `m_axis_tlast` out 1: registered output end of packet.
- `m_axis_tid` out `ID_W`: source port index of the current beat.
- `m_axis_tready` in 1: downstream ready.
- `cnt_clr` in 1: synchronous clear of all packet counters.
- `pkt_cnt` out `NUM_PORTS*CNT_W`: completed-packet count per port; port *i* occupies bits `[CNT_W*i+CNT_W-1:CNT_W*i]`.

## Operation
State machine, `state` register:
- `ARB`:
  - Search `s_axis_tvalid`, starting at port `last_grant+1` and wrapping modulo `NUM_PORTS`.
  - The first port found with valid high is the winner. Latch `grant <= winner` and go to `DATA`.
  - If no port has valid high, remain in `ARB`.
  - `s_axis_tready` is all-zero in `ARB`.
- `DATA`:
  - `s_axis_tready[grant] = out_free`, where `out_free = !m_axis_tvalid || m_axis_tready`. All other `s_axis_tready` bits are 0.
  - A beat transfers when `s_axis_tvalid[grant] && s_axis_tready[grant]`. On a transfer, load the output register: `m_axis_tdata`/`m_axis_tlast` from port `grant`, `m_axis_tid <= grant`, `m_axis_tvalid <= 1`.
  - If `out_free` is true and there is no transfer, clear `m_axis_tvalid`.
  - On a transfer with `tlast` set: `last_grant <= grant`, `pkt_cnt[grant]` increments, and the state returns to `ARB`.
- When the output register holds a beat with `m_axis_tvalid` high, it clears only after the downstream handshake, regardless of state.

Rules:
- The grant never changes mid-packet. A granted port that stalls (valid low) holds the grant indefinitely; there is no timeout.
- A single-beat packet (`tvalid` and `tlast` on the first beat) is legal: one beat, one count.
- Counters saturate at all-ones and never wrap.
- `cnt_clr` has priority over an increment in the same cycle; the result is 0.

Reset values:
- `state = ARB`, `grant = 0`.
- `last_grant = NUM_PORTS-1`, so port 0 has first priority.
- `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `m_axis_tdata = 0`, `m_axis_tid = 0`.
- `s_axis_tready = 0`; all counters 0.
- Reset mid-packet discards the packet in flight; the downstream FIFO is reset by the same `axis_aresetn`.

## Timing
- Edge 0 is the clock edge that ends cycle 0.
- Arbitration latency: valid first seen in `ARB` at cycle 0 → grant latched at edge 0 → `s_axis_tready` high in cycle 1 → first beat on `m_axis_*` in cycle 2.
- Streaming throughput is 1 beat/cycle while `m_axis_tready` is high.
- There is exactly one idle `ARB` cycle between consecutive packets, including back-to-back packets from the same port.
- When `m_axis_tready` is low, the output register holds and `s_axis_tready[grant]` drops in the same cycle (combinational from `m_axis_tready`).
- `pkt_cnt` updates at the edge of the `tlast` transfer and is visible the next cycle.
- `s_axis_tready` is a combinational function of `state`, `grant`, `m_axis_tvalid` and `m_axis_tready`. It has no dependency on `s_axis_tvalid`.

## Structure
- Package `axis_pkt_pkg` holds:
  - `arb_state_t` enum, with values `ARB` and `DATA`.
  - Byte width constant `AXIS_DW = 8`.
  - Helper function `rr_next(req, last)`.
- Sub-module `axis_rr_pick`: a combinational rotating priority picker with inputs `req[NUM_PORTS]` and `last[ID_W]`, and outputs `found` and `idx[ID_W]`. It is reusable by other arbiters in the Ethernet path.
- The top level holds the state machine, the output register and the counters.

## Test plan
- Single port: port 0 sends a 5-beat packet `01..05` with `m_axis_tready=1`. Expect `m_axis_tdata` `01..05` on cycles 2–6, `tlast` on the `05` beat, `tid=0`, `pkt_cnt[0]=1`.
- All 4 ports request continuously with 3-beat packets. Expect grant order 0,1,2,3,0 with one `ARB` cycle between packets, and no interleaving of beats from different ports within a packet.
- Backpressure: toggle `m_axis_tready` 1,0,0,1 during a 4-beat packet. Expect each byte exactly once, in order, with output held while `m_axis_tready` is low.
- Port 2 stalls valid mid-packet for 10 cycles while port 1 requests. Expect port 1's `s_axis_tready` to stay 0 until port 2's `tlast`, then port 1 granted next (`last_grant` was 2, so search starts at 3 and wraps to 1 with port 3 idle).
- Saturation with `CNT_W=4`: send 17 packets on port 3. Expect `pkt_cnt[3]=15`. Then assert `cnt_clr` in the same cycle as a `tlast` transfer. Expect 0.
- Reset asserted mid-packet. Expect all outputs to go to reset values immediately (async), with port 0 first priority after release.

Source files
------------

// File: rtl/axis_pkt_pkg.sv
// Shared types and the rotating-priority search used by the packet arbiters
// on the Ethernet receive path.
package axis_pkt_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    DATA = 1'b1
  } arb_state_t;

  localparam int AXIS_DW = 8;
  localparam int RR_MAX  = 8;

  // Returns {found, idx}. Callers zero-extend req to RR_MAX bits. Unused
  // ports never request, so wrapping modulo RR_MAX selects the same port
  // as wrapping modulo the real port count.
  function automatic logic [3:0] rr_next(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        last);
    logic [3:0] res;
    logic [2:0] p;
    res = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      p = last + 3'(k);
      if (!res[3] && req[p]) res = {1'b1, p};
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational rotating-priority picker: the first requester after 'last',
// wrapping around.
module axis_rr_pick
  import axis_pkt_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int ID_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      last,
  output logic                 found,
  output logic [ID_W-1:0]      idx
);

  logic [RR_MAX-1:0] req_w;
  logic [3:0]        res;
  logic              unused_res;

  assign req_w      = RR_MAX'(req);
  assign res        = rr_next(req_w, 3'(last));
  assign found      = res[3];
  assign idx        = res[ID_W-1:0];
  assign unused_res = ^res;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS byte streams into one tagged
// stream, with saturating per-port completed-packet counters.
module axis_pkt_arbiter
  import axis_pkt_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16,
  localparam int ID_W     = $clog2(NUM_PORTS)
) (
  input  logic                       axis_aclk,
  input  logic                       axis_aresetn,
  input  logic [NUM_PORTS*8-1:0]     s_axis_tdata,
  input  logic [NUM_PORTS-1:0]       s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]       s_axis_tlast,
  output logic [NUM_PORTS-1:0]       s_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic [ID_W-1:0]            m_axis_tid,
  input  logic                       m_axis_tready,
  input  logic                       cnt_clr,
  output logic [NUM_PORTS*CNT_W-1:0] pkt_cnt
);

  arb_state_t                         state;
  logic [ID_W-1:0]                    grant, last_grant;
  logic                               pick_found;
  logic [ID_W-1:0]                    pick_idx;
  logic                               out_free, xfer, pkt_done;
  logic [AXIS_DW-1:0]                 beat_data;
  logic                               beat_last;
  logic [NUM_PORTS-1:0]               done_oh;
  logic [NUM_PORTS-1:0][CNT_W-1:0]    cnt_q;

  axis_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req   (s_axis_tvalid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign beat_data = s_axis_tdata[AXIS_DW*grant +: AXIS_DW];
  assign beat_last = s_axis_tlast[grant];
  assign xfer      = (state == DATA) && s_axis_tvalid[grant] && out_free;
  assign pkt_done  = xfer && beat_last;
  assign done_oh   = pkt_done ? (NUM_PORTS'(1) << grant) : '0;

  // Ready never looks at tvalid, so sources may wait on it safely.
  always_comb begin
    s_axis_tready = '0;
    if (state == DATA) s_axis_tready[grant] = out_free;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state         <= ARB;
      grant         <= '0;
      last_grant    <= ID_W'(NUM_PORTS-1);
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
    end else begin
      if (xfer) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= beat_data;
        m_axis_tlast  <= beat_last;
        m_axis_tid    <= grant;
      end else if (out_free) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        ARB: if (pick_found) begin
          grant <= pick_idx;
          state <= DATA;
        end
        DATA: if (pkt_done) begin
          last_grant <= grant;
          state      <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  // Clear beats a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cnt_clr)
          cnt_q[i] <= '0;
        else if (done_oh[i] && (cnt_q[i] != {CNT_W{1'b1}}))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign pkt_cnt = cnt_q;

endmodule
